// File: rtl/register_scoreboard_pkg.sv
// Shared decode-stage types for the register write-pending scoreboard.
package id_stage_params;
    localparam int SCOREBOARD_COUNT_WIDTH = 2;
    localparam int SCOREBOARD_MAX         = 3;
    localparam int NUM_REGS               = 32;

    typedef logic [4:0]                        RegisterAddress;
    typedef logic [SCOREBOARD_COUNT_WIDTH-1:0] ScoreboardCount;

    // r0 is hardwired zero, so it never carries a pending write.
    function automatic logic tracked(input RegisterAddress address);
        return address != 5'd0;
    endfunction
endpackage

// File: rtl/register_scoreboard_counter.sv
// One saturating in-flight write counter for a single GPR.
module scoreboard_counter #(
    parameter int COUNT_WIDTH   = 2,
    parameter int MAX_IN_FLIGHT = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inc,
    input  logic                   dec,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   at_max,
    output logic                   underflow
);
    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_IN_FLIGHT);

    // Simultaneous issue and retire cancel; the ends of the range hold rather than wrap.
    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (inc && !dec && count != MAX_COUNT)
            count <= count + COUNT_WIDTH'(1);
        else if (dec && !inc && count != '0)
            count <= count - COUNT_WIDTH'(1);
    end

    assign at_max    = count == MAX_COUNT;
    assign underflow = dec && count == '0;
endmodule

// File: rtl/register_scoreboard.sv
// Per-GPR write-pending scoreboard and decode issue interlock.
module register_scoreboard
    import id_stage_params::*;
#(
    parameter int MAX_IN_FLIGHT = SCOREBOARD_MAX,
    parameter int COUNT_WIDTH   = SCOREBOARD_COUNT_WIDTH
) (
    input  logic           clock,
    input  logic           reset,
    input  RegisterAddress source1_address,
    input  logic           source1_used,
    input  RegisterAddress source2_address,
    input  logic           source2_used,
    input  logic           dest_write,
    input  RegisterAddress dest_address,
    input  logic           issue_fire,
    input  logic           retire_valid,
    input  RegisterAddress retire_address,
    input  logic           flush,
    output logic           ready_go,
    output logic           stall_source1,
    output logic           stall_source2,
    output logic [4:0]     in_flight_total,
    output logic           underflow_error
);
    logic [NUM_REGS-1:0][COUNT_WIDTH-1:0] counts;
    logic [NUM_REGS-1:0]                  at_max_vec;
    logic [NUM_REGS-1:0]                  underflow_vec;
    logic                                 full_stall;

    assign counts[0]        = '0;
    assign at_max_vec[0]    = 1'b0;
    assign underflow_vec[0] = 1'b0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        scoreboard_counter #(
            .COUNT_WIDTH  (COUNT_WIDTH),
            .MAX_IN_FLIGHT(MAX_IN_FLIGHT)
        ) u_counter (
            .clock    (clock),
            .reset    (reset),
            .inc      (issue_fire && dest_write && dest_address == RegisterAddress'(i)),
            .dec      (retire_valid && retire_address == RegisterAddress'(i)),
            .clear    (flush),
            .count    (counts[i]),
            .at_max   (at_max_vec[i]),
            .underflow(underflow_vec[i])
        );
    end

    // Hazards look at registered counts only: a retire this cycle releases next cycle.
    assign stall_source1 = source1_used && tracked(source1_address) && counts[source1_address] != '0;
    assign stall_source2 = source2_used && tracked(source2_address) && counts[source2_address] != '0;
    assign full_stall    = dest_write && at_max_vec[dest_address];
    assign ready_go      = !(stall_source1 || stall_source2 || full_stall);

    always_comb begin
        in_flight_total = '0;
        for (int i = 1; i < NUM_REGS; i++)
            in_flight_total = in_flight_total + 5'(counts[i] != '0);
    end

    always_ff @(posedge clock) begin
        if (reset)
            underflow_error <= 1'b0;
        else if (|underflow_vec)
            underflow_error <= 1'b1;
    end
endmodule
